// File: rtl/delay_unit_sched_pkg.sv
// delay_unit_sched_pkg: shared tag type and width helper for the delay-unit scheduler.
package delay_unit_sched_pkg;

    localparam int TAG_W = 1;

    typedef logic [TAG_W-1:0] req_id_t;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sched_tag_fifo.sv
// sched_tag_fifo: in-order FIFO of requester tags for beats issued into the delay unit.
module sched_tag_fifo
    import delay_unit_sched_pkg::*;
#(
    parameter int TAG_DEPTH = 4,
    parameter int TAG_W     = 1
) (
    input  logic                          CLK,
    input  logic                          ASYNCRESETN,
    input  logic                          push,
    input  logic [TAG_W-1:0]              push_tag,
    input  logic                          pop,
    output logic [TAG_W-1:0]              head_tag,
    output logic                          empty,
    output logic                          full,
    output logic [cnt_w(TAG_DEPTH)-1:0]   count
);
    localparam int PW = $clog2(TAG_DEPTH);
    localparam int CW = cnt_w(TAG_DEPTH);

    logic [TAG_W-1:0] mem_q [TAG_DEPTH];
    logic [PW-1:0]    wr_q, rd_q;
    logic [CW-1:0]    cnt_q, cnt_d;

    assign cnt_d = cnt_q + CW'(push) - CW'(pop);

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < TAG_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (push) begin
                mem_q[wr_q] <= push_tag;
                wr_q        <= wr_q + PW'(1);
            end
            if (pop) rd_q <= rd_q + PW'(1);
            cnt_q <= cnt_d;
        end
    end

    assign head_tag = mem_q[rd_q];
    assign empty    = cnt_q == '0;
    assign full     = cnt_q == CW'(TAG_DEPTH);
    assign count    = cnt_q;

endmodule

// File: rtl/delay_unit_scheduler.sv
// delay_unit_scheduler: round-robin sharing of one in-order delay-unit lane between two
// requesters, with a tag FIFO steering each returning beat back to its issuer.
module delay_unit_scheduler
    import delay_unit_sched_pkg::*;
#(
    parameter int DATA_W    = 5,
    parameter int TAG_DEPTH = 4
) (
    input  logic                          CLK,
    input  logic                          ASYNCRESETN,
    input  logic [DATA_W-1:0]             REQ_0_data,
    input  logic                          REQ_0_valid,
    output logic                          REQ_0_ready,
    input  logic [DATA_W-1:0]             REQ_1_data,
    input  logic                          REQ_1_valid,
    output logic                          REQ_1_ready,
    output logic [DATA_W-1:0]             DU_IN_data,
    output logic                          DU_IN_valid,
    input  logic                          DU_IN_ready,
    input  logic [DATA_W-1:0]             DU_OUT_data,
    input  logic                          DU_OUT_valid,
    output logic                          DU_OUT_ready,
    output logic [DATA_W-1:0]             RESP_0_data,
    output logic                          RESP_0_valid,
    input  logic                          RESP_0_ready,
    output logic [DATA_W-1:0]             RESP_1_data,
    output logic                          RESP_1_valid,
    input  logic                          RESP_1_ready,
    output logic [cnt_w(TAG_DEPTH)-1:0]   IN_FLIGHT,
    output logic                          ERR_ORPHAN
);
    req_id_t gnt, head, last_q, last_d, lock_id_q, lock_id_d;
    logic    lock_q, lock_d, err_q, err_d;
    logic    empty, full, push, pop, can_push, elig0, elig1;

    // A pop this cycle frees a slot, so a full FIFO can still take a new beat.
    assign can_push = !full || pop;
    assign elig0    = ASYNCRESETN && REQ_0_valid && can_push;
    assign elig1    = ASYNCRESETN && REQ_1_valid && can_push;

    always_comb begin
        gnt         = lock_q ? lock_id_q : (elig0 && elig1) ? ~last_q : req_id_t'(elig1);
        DU_IN_valid = gnt[0] ? elig1 : elig0;
        DU_IN_data  = gnt[0] ? REQ_1_data : REQ_0_data;
        push        = DU_IN_valid && DU_IN_ready;
        REQ_0_ready = push && !gnt[0];
        REQ_1_ready = push && gnt[0];
    end

    always_comb begin
        DU_OUT_ready = ASYNCRESETN && !empty && (head[0] ? RESP_1_ready : RESP_0_ready);
        pop          = DU_OUT_valid && DU_OUT_ready;
        RESP_0_valid = ASYNCRESETN && !empty && DU_OUT_valid && !head[0];
        RESP_1_valid = ASYNCRESETN && !empty && DU_OUT_valid && head[0];
        RESP_0_data  = DU_OUT_data;
        RESP_1_data  = DU_OUT_data;
    end

    // The lock pins the grant while an offered beat is stalled, keeping DU_IN stable.
    always_comb begin
        lock_d    = push ? 1'b0 : DU_IN_valid ? 1'b1 : lock_q;
        lock_id_d = (DU_IN_valid && !DU_IN_ready) ? gnt : lock_id_q;
        last_d    = push ? gnt : last_q;
        err_d     = err_q || (empty && DU_OUT_valid);
    end

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            lock_q    <= 1'b0;
            lock_id_q <= '0;
            last_q    <= req_id_t'(1);
            err_q     <= 1'b0;
        end else begin
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
            last_q    <= last_d;
            err_q     <= err_d;
        end
    end

    assign ERR_ORPHAN = err_q;

    sched_tag_fifo #(
        .TAG_DEPTH (TAG_DEPTH),
        .TAG_W     (TAG_W)
    ) u_tag_fifo (
        .CLK         (CLK),
        .ASYNCRESETN (ASYNCRESETN),
        .push        (push),
        .push_tag    (gnt),
        .pop         (pop),
        .head_tag    (head),
        .empty       (empty),
        .full        (full),
        .count       (IN_FLIGHT)
    );

endmodule
